// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
//   Converts a 7-bit score to three BCD digits (serial double-dabble, one bit
//   per clock) and clamps a 7-bit lives count to a single digit (0..9). The
//   four digits are then time-multiplexed onto a common-anode 7-segment
//   display.
//
//   Conversion sequence: IDLE captures a changed {score, lives} pair, SHIFT
//   runs 7 shift-add-3 steps, and DONE loads all four digit registers in a
//   single edge. The shown digits therefore only ever move from one complete
//   result to the next.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (2 .. 2**20)
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   score  binary score 0..127
//   lives  binary lives 0..127 (shown as min(lives, 9))
//   seg    segments {g,f,e,d,c,b,a}, active-low, registered
//   an     digit enables, active-low one-hot, registered
//          an[0] units, an[1] tens, an[2] hundreds, an[3] lives
//   busy   high while a conversion is in progress (SHIFT or DONE)
//
// Build option
//   SCORE_DISPLAY_BLANK_EN  blank a leading-zero hundreds digit, and a zero
//                           tens digit when hundreds is also zero
// ---------------------------------------------------------------------------
module score_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score,
    input  logic [6:0] lives,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [6:0]      cap_score_q, cap_lives_q;
    logic [6:0]      shreg_q;
    logic [11:0]     bcd_q;
    logic [2:0]      iter_q;
    logic [3:0]      dig_h_q, dig_t_q, dig_u_q, dig_l_q;
    logic [CntW-1:0] scan_q;
    logic [1:0]      idx_q;

    logic            changed, capture, do_shift, load;
    logic [11:0]     bcd_adj, bcd_next;
    logic [3:0]      sel_digit;
    logic            blank;
    logic [6:0]      seg_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign changed = ({score, lives} != {cap_score_q, cap_lives_q});

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (changed) state_d = StShift;
            StShift: if (iter_q == 3'd6) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---- FSM: outputs / datapath controls ----
    always_comb begin
        busy     = (state_q != StIdle);
        capture  = (state_q == StIdle) && changed;
        do_shift = (state_q == StShift);
        load     = (state_q == StDone);
    end

    // One double-dabble step: correct each nibble >= 5, then shift in the next score bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[10:0], shreg_q[6]};
    end

    // ---- Conversion datapath and digit registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_score_q <= '0;
            cap_lives_q <= '0;
            shreg_q     <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            dig_h_q     <= '0;
            dig_t_q     <= '0;
            dig_u_q     <= '0;
            dig_l_q     <= '0;
        end else begin
            if (capture) begin
                cap_score_q <= score;
                cap_lives_q <= lives;
                shreg_q     <= score;
                bcd_q       <= '0;
                iter_q      <= '0;
            end
            if (do_shift) begin
                bcd_q   <= bcd_next;
                shreg_q <= {shreg_q[5:0], 1'b0};
                iter_q  <= iter_q + 3'd1;
            end
            if (load) begin
                dig_h_q <= bcd_q[11:8];
                dig_t_q <= bcd_q[7:4];
                dig_u_q <= bcd_q[3:0];
                dig_l_q <= (cap_lives_q > 7'd9) ? 4'd9 : cap_lives_q[3:0];
            end
        end
    end

    // ---- Digit scan ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == CntW'(SCAN_DIV - 1)) begin
            scan_q <= '0;
            idx_q  <= idx_q + 2'd1;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    sel_digit = dig_u_q;
            2'd1:    sel_digit = dig_t_q;
            2'd2:    sel_digit = dig_h_q;
            default: sel_digit = dig_l_q;
        endcase
        blank = 1'b0;
`ifdef SCORE_DISPLAY_BLANK_EN
        if (idx_q == 2'd2) begin
            blank = (dig_h_q == 4'd0);
        end else if (idx_q == 2'd1) begin
            blank = (dig_h_q == 4'd0) && (dig_t_q == 4'd0);
        end
`endif
        seg_d = blank ? 7'b1111111 : seg_decode(sel_digit);
    end

    // an and seg come from the same idx_q sample, so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= ~(4'b0001 << idx_q);
            seg <= seg_d;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// ---------------------------------------------------------------------------
// tb_score_display
//   Self-checking bench for score_display with SCAN_DIV = 4. A behavioural
//   model (busy-cycle countdown, decimal arithmetic for the digits, slot index
//   from an edge count) predicts busy/an/seg every cycle; directed scenarios
//   add literal expectations, followed by randomized input changes and
//   asynchronous reset pulses.
// ---------------------------------------------------------------------------
module tb_score_display;

    localparam int unsigned SCAN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] score;
    logic [6:0] lives;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    score_display #(.SCAN_DIV(SCAN)) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .lives (lives),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input int d);
        case (d)
            0:       dec = 7'b1000000;
            1:       dec = 7'b1111001;
            2:       dec = 7'b0100100;
            3:       dec = 7'b0110000;
            4:       dec = 7'b0011001;
            5:       dec = 7'b0010010;
            6:       dec = 7'b0000010;
            7:       dec = 7'b1111000;
            8:       dec = 7'b0000000;
            9:       dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    endfunction

    // ---- Behavioural model ----
    int         m_busy;     // remaining busy cycles of the current conversion
    int         m_edges;    // clock edges since reset
    int         m_idx;      // digit slot: 0 units, 1 tens, 2 hundreds, 3 lives
    logic [6:0] m_cs, m_cl; // last captured pair
    int         m_dig[4];
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_busy;

    function automatic logic [6:0] shown(input int slot);
        logic [6:0] s;
        s = dec(m_dig[slot]);
`ifdef SCORE_DISPLAY_BLANK_EN
        if (slot == 2 && m_dig[2] == 0) s = 7'b1111111;
        if (slot == 1 && m_dig[2] == 0 && m_dig[1] == 0) s = 7'b1111111;
`endif
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 0;
            m_edges  = 0;
            m_idx    = 0;
            m_cs     = '0;
            m_cl     = '0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            exp_an   = 4'b1110;
            exp_seg  = 7'b1000000;
            exp_busy = 1'b0;
        end else begin
            exp_an  = ~(4'b0001 << m_idx);
            exp_seg = shown(m_idx);
            m_edges++;
            m_idx = (m_edges / SCAN) % 4;
            if (m_busy == 0) begin
                if (score != m_cs || lives != m_cl) begin
                    m_cs   = score;
                    m_cl   = lives;
                    m_busy = 8;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_dig[0] = m_cs % 10;
                    m_dig[1] = (m_cs / 10) % 10;
                    m_dig[2] = m_cs / 100;
                    m_dig[3] = (m_cl > 9) ? 9 : int'(m_cl);
                end
            end
            exp_busy = (m_busy != 0);
        end
    end

    // ---- Per-cycle compare ----
    always @(negedge clk) begin
        if (check_en) begin
            check("busy", busy, exp_busy);
            check("an", an, exp_an);
            check("seg", seg, exp_seg);
        end
    end

    // ---- Stimulus helpers ----
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: busy still %b after 64 cycles", busy);
        end
    endtask

    task automatic wait_an(input logic [3:0] t);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an === t) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_an: an is %b, never reached %b", an, t);
        end
    endtask

    initial begin
        int bc;
        rst   = 1'b1;
        score = 7'd0;
        lives = 7'd3;
        #7;
        check_en = 1'b1;
        check("reset_an", an, 4'b1110);
        check("reset_seg", seg, 7'b1000000);
        check("reset_busy", busy, 1'b0);
        cycles(2);
        rst = 1'b0;

        // Release with score 0 / lives 3: busy for exactly 8 cycles, lives shows 3.
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
        end
        check("busy_len", bc, 8);
        wait_an(4'b0111);
        check("lives3_seg", seg, 7'b0110000);

        // Score 127 shows 1,2,7.
        score = 7'd127;
        wait_idle();
        wait_an(4'b1011);
        check("s127_hund", seg, 7'b1111001);
        wait_an(4'b1101);
        check("s127_tens", seg, 7'b0100100);
        wait_an(4'b1110);
        check("s127_units", seg, 7'b1111000);

        // Change 5 -> 9 on the 3rd SHIFT cycle: one idle cycle, then reconvert.
        score = 7'd5;
        cycles(3);
        score = 7'd9;
        wait_idle();
        @(negedge clk);
        check("reconv_busy", busy, 1'b1);
        wait_idle();
        wait_an(4'b1110);
        check("s9_units", seg, 7'b0010000);

        // Lives clamp and zero.
        lives = 7'd12;
        wait_idle();
        wait_an(4'b0111);
        check("lives12_seg", seg, 7'b0010000);
        lives = 7'd0;
        wait_idle();
        wait_an(4'b0111);
        check("lives0_seg", seg, 7'b1000000);

        // Score 7 leading-zero handling.
        score = 7'd7;
        wait_idle();
        wait_an(4'b1011);
`ifdef SCORE_DISPLAY_BLANK_EN
        check("s7_hund", seg, 7'b1111111);
        wait_an(4'b1101);
        check("s7_tens", seg, 7'b1111111);
`else
        check("s7_hund", seg, 7'b1000000);
        wait_an(4'b1101);
        check("s7_tens", seg, 7'b1000000);
`endif
        wait_an(4'b1110);
        check("s7_units", seg, 7'b1111000);

        // Reset mid-SHIFT while converting 99.
        score = 7'd99;
        cycles(3);
        #2 rst = 1'b1;
        #1;
        check("midrst_an", an, 4'b1110);
        check("midrst_seg", seg, 7'b1000000);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        wait_an(4'b1110);
        check("s99_units", seg, 7'b0010000);

        // Randomized input changes and reset pulses.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                #($urandom_range(1, 4)) rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 1) score = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 3) == 0) lives = 7'($urandom_range(0, 127));
                cycles($urandom_range(1, 12));
            end
        end
        wait_idle();
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 score  input  7  binary score from the game block (0..127).
REQ-005 lives  input  7  binary remaining lives from the game block (0..127).
REQ-006 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-007 an  output  4  digit enables, active-low one-hot; an[0] score units, an[1] score tens, an[2] score hundreds, an[3] lives.
REQ-008 busy  output  1  high while a conversion is in progress.

Function
REQ-009 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-010 IDLE: if {score,lives} differs from the last captured pair, the block SHALL capture both inputs, clear the BCD accumulator and enter SHIFT with iteration count 0; otherwise it SHALL stay in IDLE.
REQ-011 SHIFT: the block SHALL perform one shift-add-3 (double-dabble) step per cycle on the captured score, MSB first; each BCD nibble >=5 gets +3 before the shift.
REQ-012 SHIFT SHALL last exactly 7 cycles, then go to DONE.
REQ-013 DONE: the block SHALL load the hundreds, tens and units digit registers, load the lives digit register with min(captured lives, 9), then return to IDLE.
REQ-014 Latency: the digit registers SHALL update on the 8th rising edge after the capture edge.
REQ-015 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-016 Input changes during SHIFT/DONE SHALL be ignored; the mismatch is detected in the following IDLE cycle and triggers a new conversion.
REQ-017 The displayed digits SHALL never show a partially converted value.
REQ-018 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-019 an SHALL be the active-low one-hot of the digit index, registered, with exactly one bit low at all times after reset.
REQ-020 seg SHALL be the registered decode of the selected digit register, updated on the same edge as an.
REQ-021 Decode table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-022 Score 127 SHALL display as 1,2,7; lives 0 SHALL display as 0 and lives >=10 as 9.

Reset
REQ-023 On rst: state IDLE, captured pair 0/0, all digit registers 0, scan counter 0, digit index 0, busy 0.
REQ-024 On rst: an=1110 and seg=1000000, asserted asynchronously.
REQ-025 Reset asserted during SHIFT SHALL abort the conversion with no digit-register update.
REQ-026 After release, the block SHALL reconvert if the inputs are non-zero.

Configuration
REQ-027 Macro SCORE_DISPLAY_BLANK_EN defined: a zero hundreds digit SHALL display blank; a zero tens digit SHALL display blank when hundreds is also zero; units and lives are never blanked.
REQ-028 Macro SCORE_DISPLAY_BLANK_EN undefined: all four digits SHALL always show their decoded value, including leading zeros.

Verification (SCAN_DIV=4 for all scenarios)
REQ-029 Release reset with score=0, lives=3 -> busy high for 8 cycles; then digits {0,0,0,3}; an cycles 1110,1101,1011,0111 every 4 clocks; seg on an[3] = 0110000.
REQ-030 score 0->127 in IDLE -> digit registers 1,2,7 exactly 8 edges after the capture edge; no intermediate value ever appears on seg.
REQ-031 score changes 5->9 on the 3rd SHIFT cycle -> first result shows 5; busy drops for one cycle; a second conversion then shows 9.
REQ-032 lives=12 -> lives digit shows 9 (seg 0010000); lives=0 -> seg 1000000 on an[3].
REQ-033 score=7 with SCORE_DISPLAY_BLANK_EN -> hundreds/tens seg 1111111, units 1111000; without the macro -> 1000000, 1000000, 1111000.
REQ-034 rst pulsed mid-SHIFT while converting 99 -> an=1110, seg=1000000 immediately; digits stay 0 until reconversion after release completes.
